// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encodings and word/byte constants for mem_ctrl
package mem_ctrl_pkg;

  localparam int WORD_W         = 32;
  localparam int RAM_DW         = 8;
  localparam int BYTES_PER_WORD = WORD_W / RAM_DW;

  // Reads need one extra cycle to catch the last byte behind the RAM latency.
  localparam logic [2:0] LAST_RD_CNT = 3'd4;
  localparam logic [2:0] LAST_WR_CNT = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  function automatic logic [RAM_DW-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                  input logic [1:0] idx);
    word_byte = word[idx*RAM_DW +: RAM_DW];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [WORD_W-1:0]   if_addr,
  output logic [WORD_W-1:0]   if_data,
  output logic                stallreq_if,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [WORD_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_wdata,
  input  logic [3:0]          mem_sel,
  output logic [WORD_W-1:0]   mem_rdata,
  output logic                stallreq_mem,
  output logic [WORD_W-1:0]   ram_addr,
  output logic                ram_wr,
  output logic [RAM_DW-1:0]   ram_dout,
  input  logic [RAM_DW-1:0]   ram_din
);

  state_t              state;
  owner_t              owner;
  logic [2:0]          cnt;
  logic [WORD_W-1:0]   base;
  logic [WORD_W-1:0]   wdata;
  logic [3:0]          sel;
  logic [23:0]         rd_buf;
  logic                busy;
  logic [2:0]          offs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      cnt       <= 3'd0;
      base      <= '0;
      wdata     <= '0;
      sel       <= 4'd0;
      rd_buf    <= 24'd0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 3'd0;
          // MEM has priority; IF may starve while mem_req stays high.
          if (mem_req) begin
            base  <= mem_addr;
            wdata <= mem_wdata;
            sel   <= mem_sel;
            owner <= OWN_MEM;
            state <= mem_we ? ST_MEM_WR : ST_MEM_RD;
          end else if (if_req) begin
            base  <= if_addr;
            owner <= OWN_IF;
            state <= ST_IF_RD;
          end
        end
        ST_IF_RD, ST_MEM_RD: begin
          case (cnt)
            3'd1:    rd_buf[7:0]   <= ram_din;
            3'd2:    rd_buf[15:8]  <= ram_din;
            3'd3:    rd_buf[23:16] <= ram_din;
            default: ;
          endcase
          if (cnt == LAST_RD_CNT) begin
            state <= ST_DONE;
            if (state == ST_IF_RD) if_data   <= {ram_din, rd_buf};
            else                   mem_rdata <= {ram_din, rd_buf};
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_MEM_WR: begin
          if (cnt == LAST_WR_CNT) state <= ST_DONE;
          else                    cnt   <= cnt + 3'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The final read cycle keeps the last byte address so a top-of-memory word never shows address 0.
  always_comb begin
    busy = (state == ST_IF_RD) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
    offs = (cnt > 3'd3) ? 3'd3 : cnt;
    ram_addr = busy ? base + {29'd0, offs} : '0;
    ram_wr   = !rst && (state == ST_MEM_WR) && sel[cnt[1:0]];
    ram_dout = (state == ST_MEM_WR) ? word_byte(wdata, cnt[1:0]) : '0;
  end

  assign stallreq_if  = !rst && if_req  && !((state == ST_DONE) && (owner == OWN_IF));
  assign stallreq_mem = !rst && mem_req && !((state == ST_DONE) && (owner == OWN_MEM));

endmodule
